// File: rtl/send_output_file_if.sv
// send_output_file_if: start/memory/UART-TX/status bundle for the bit-memory dumper.
interface send_output_file_if #(parameter int ADDR_W = 10);
  logic start;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_q;
  logic [7:0] tx_data;
  logic tx_trmt;
  logic tx_done;
  logic busy;
  logic done;
  modport master(output start, mem_q, tx_done, input mem_addr, tx_data, tx_trmt, busy, done);
  modport slave(input start, mem_q, tx_done, output mem_addr, tx_data, tx_trmt, busy, done);
endinterface

// File: rtl/send_output_file.sv
// send_output_file: packs the bit memory LSB-first into bytes and streams them to the UART TX.
// Optional SEND_CHECKSUM_EN appends one mod-256 sum byte after the data bytes.
module send_output_file #(
  parameter int NUM_BITS = 784,
  parameter int ADDR_W = 10
) (
  input logic clk,
  input logic rst,
  send_output_file_if.slave bus
);
  localparam int NUM_BYTES = NUM_BITS / 8;
  localparam int KW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, WAIT_TX, FINISH} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic [2:0] j;
  logic [7:0] shreg;
  logic last;
`ifdef SEND_CHECKSUM_EN
  logic [7:0] checksum;
  logic ck_phase;
`endif
  assign last = k == KW'(NUM_BYTES - 1);
  // mem_addr walks 8k+j by increment: the last address of byte k is one below byte k+1's first
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      j <= '0;
      shreg <= '0;
      bus.mem_addr <= '0;
      bus.tx_data <= '0;
      bus.tx_trmt <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
`ifdef SEND_CHECKSUM_EN
      checksum <= '0;
      ck_phase <= 1'b0;
`endif
    end else begin
      bus.tx_trmt <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= FETCH;
          k <= '0;
          j <= '0;
          bus.busy <= 1'b1;
          bus.mem_addr <= '0;
`ifdef SEND_CHECKSUM_EN
          checksum <= '0;
          ck_phase <= 1'b0;
`endif
        end
        FETCH: begin
          if (j != 3'd0) shreg <= {bus.mem_q, shreg[7:1]};
          j <= j + 3'd1;
          if (j == 3'd7) state <= CAPTURE;
          else bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
        end
        CAPTURE: begin
          shreg <= {bus.mem_q, shreg[7:1]};
          bus.tx_data <= {bus.mem_q, shreg[7:1]};
          bus.tx_trmt <= 1'b1;
          state <= SEND;
        end
        SEND: begin
`ifdef SEND_CHECKSUM_EN
          if (!ck_phase) checksum <= checksum + shreg;
`endif
          state <= WAIT_TX;
        end
        WAIT_TX: if (bus.tx_done) begin
          if (!last) begin
            k <= k + KW'(1);
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
            state <= FETCH;
          end
`ifdef SEND_CHECKSUM_EN
          else if (!ck_phase) begin
            ck_phase <= 1'b1;
            bus.tx_data <= checksum;
            bus.tx_trmt <= 1'b1;
            state <= SEND;
          end
`endif
          else begin
            bus.done <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          bus.busy <= 1'b0;
          bus.mem_addr <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_send_output_file.sv
// tb_send_output_file: directed dumps against a bit-memory model and a UART TX responder.
module tb_send_output_file;
`ifdef SEND_CHECKSUM_EN
  localparam int EXP_N = 99;
`else
  localparam int EXP_N = 98;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 1;
  int spur_at = -1;
  int stop_n = 1 << 30;
  int cnt = 0;
  int done_cnt = 0;
  int done_nobusy = 0;
  int max_addr = 0;
  int last_max = 0;
  logic mem [0:783];
  logic [7:0] bytes [$];
  int tcyc [$];

  send_output_file_if #(.ADDR_W(10)) bus();
  send_output_file dut(.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.mem_q <= mem[bus.mem_addr];

  // UART TX responder: tx_done lat cycles after each strobe, optional spurious pulse
  always @(negedge clk) begin
    bus.tx_done = (cnt == 1) || (cyc == spur_at);
    if (rst) cnt = 0;
    else if (cnt > 0) cnt = cnt - 1;
    if (bus.tx_trmt) begin
      bytes.push_back(bus.tx_data);
      tcyc.push_back(cyc);
      cnt = (bytes.size() < stop_n) ? lat : 0;
    end
    if (int'(bus.mem_addr) > max_addr) max_addr = int'(bus.mem_addr);
    if (bus.done) begin
      done_cnt++;
      if (!bus.busy) done_nobusy++;
      last_max = max_addr;
      max_addr = 0;
    end
  end

  task automatic fill(input logic [7:0] v, input bit counting);
    logic [7:0] b;
    for (int kk = 0; kk < 98; kk++) begin
      b = counting ? 8'(kk) : v;
      for (int i = 0; i < 8; i++) mem[8*kk+i] = b[i];
    end
  endtask

  task automatic run(input int l, input int xs, input int spur_off, output int n0, output int d0, output int sc);
    int t;
    n0 = bytes.size();
    d0 = done_cnt;
    lat = l;
    @(negedge clk);
    bus.start = 1'b1;
    sc = cyc;
    spur_at = spur_off > 0 ? cyc + spur_off : -1;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 20000) begin
      @(negedge clk);
      t++;
      bus.start = (t == xs);
    end
    bus.start = 1'b0;
    tests++;
    if (done_cnt == d0) begin
      fails++;
      $display("FAIL run_timeout: no done after %0d cycles, required done within 20000", t);
    end
  endtask

  task automatic check_bytes(input string nm, input int n0, input bit counting, input logic [7:0] v);
    int bad;
    logic [7:0] e;
    bad = -1;
    tests++;
    if (bytes.size() - n0 !== EXP_N) begin
      fails++;
      $display("FAIL %s_count: got %0d strobes, required %0d", nm, bytes.size() - n0, EXP_N);
    end
    for (int i = 0; i < 98 && n0 + i < bytes.size(); i++)
      if (bad < 0 && bytes[n0+i] !== (counting ? 8'(i) : v)) bad = i;
    tests++;
    if (bad >= 0) begin
      e = counting ? 8'(bad) : v;
      fails++;
      $display("FAIL %s_data: byte %0d got %h, required %h", nm, bad, bytes[n0+bad], e);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.mem_addr !== 10'd0) begin fails++; $display("FAIL reset_mem_addr: got %0d, required 0", bus.mem_addr); end
    tests++;
    if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h, required 00", bus.tx_data); end
    tests++;
    if ({bus.tx_trmt, bus.busy, bus.done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: trmt/busy/done got %b, required 000", {bus.tx_trmt, bus.busy, bus.done});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pattern(input logic [7:0] v, input int l);
    int n0, d0, sc;
    fill(v, 1'b0);
    run(l, 0, 0, n0, d0, sc);
    check_bytes($sformatf("pattern_%h", v), n0, 1'b0, v);
    @(negedge clk);
    tests++;
    if (done_cnt - d0 !== 1 || done_nobusy !== 0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL pattern_%h_done: done pulses %0d busy-low-at-done %0d busy after %b, required 1 0 0",
               v, done_cnt - d0, done_nobusy, bus.busy);
    end
  endtask

  task automatic test_counting;
    int n0, d0, sc, bad;
    int sum;
    fill(8'h00, 1'b1);
    run(1, 0, 0, n0, d0, sc);
    check_bytes("counting", n0, 1'b1, 8'h00);
    tests++;
    if (last_max !== 783) begin fails++; $display("FAIL counting_max_addr: got %0d, required 783", last_max); end
    tests++;
    if (tcyc[n0] - sc !== 10) begin fails++; $display("FAIL counting_first_trmt: got %0d cycles after start, required 10", tcyc[n0] - sc); end
    bad = -1;
    for (int i = 1; i < 98; i++) if (bad < 0 && tcyc[n0+i] - tcyc[n0+i-1] !== 11) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL counting_spacing: strobe %0d gap %0d, required 11", bad, tcyc[n0+bad] - tcyc[n0+bad-1]);
    end
`ifdef SEND_CHECKSUM_EN
    sum = 0;
    for (int i = 0; i < 98; i++) sum += i;
    tests++;
    if (bytes.size() <= n0 + 98 || bytes[n0+98] !== 8'(sum)) begin
      fails++;
      $display("FAIL counting_checksum: got %h, required %h", bytes.size() > n0 + 98 ? bytes[n0+98] : 8'hxx, 8'(sum));
    end
`else
    sum = 0;
`endif
  endtask

  task automatic test_back_to_back;
    int n0, d0, sc, n1;
    fill(8'h00, 1'b1);
    run(5, 30, 3, n0, d0, sc);
    spur_at = -1;
    check_bytes("b2b", n0, 1'b1, 8'h00);
    n1 = bytes.size();
    repeat (30) @(negedge clk);
    tests++;
    if (bytes.size() !== n1 || done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL b2b_extra: extra strobes %0d done pulses %0d, required 0 and 1", bytes.size() - n1, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int n0, d0, sc, t;
    fill(8'h00, 1'b1);
    n0 = bytes.size();
    d0 = done_cnt;
    stop_n = n0 + 41;
    lat = 1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while (bytes.size() < n0 + 41 && t < 20000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    tests++;
    if (bytes.size() !== n0 + 41 || bytes[n0+40] !== 8'd40 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_hold: strobes %0d busy %b, required 41 and 1 with byte 40 = 28", bytes.size() - n0, bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.mem_addr !== 10'd0 || bus.tx_data !== 8'h00 || {bus.tx_trmt, bus.busy, bus.done} !== 3'b000) begin
      fails++;
      $display("FAIL rstmid_outputs: addr %0d data %h trmt/busy/done %b, required 0 00 000",
               bus.mem_addr, bus.tx_data, {bus.tx_trmt, bus.busy, bus.done});
    end
    @(negedge clk);
    rst = 1'b0;
    stop_n = 1 << 30;
    repeat (5) @(negedge clk);
    tests++;
    if (done_cnt !== d0) begin fails++; $display("FAIL rstmid_no_done: got %0d done pulses, required 0", done_cnt - d0); end
    run(1, 0, 0, n0, d0, sc);
    check_bytes("rstmid_restart", n0, 1'b1, 8'h00);
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < 784; i++) mem[i] = 1'b0;
    test_reset;
    test_pattern(8'hFF, 50);
    test_pattern(8'h99, 1);
    test_pattern(8'h00, 1);
    test_pattern(8'hC3, 1);
    test_pattern(8'h93, 1);
    test_counting;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
